// File: rtl/counter_reg_3state_if.sv
// Bus-side signal bundle for counter_reg_3state.
// There is no valid/ready handshake on this bus. Every command line
// (wr, inc, dec, push, pop) is a level that the register samples on each
// rising clk edge. rd is purely combinational and only gates the
// tri-state d_out driver.
interface counter_reg_3state_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  wire  [WIDTH-1:0] d_out;
  logic [WIDTH-1:0] q;
  logic             wr;
  logic             rd;
  logic             inc;
  logic             dec;
  logic             push;
  logic             pop;
  logic             carry;
  logic             zero;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  // Bus master: issues commands and load data, observes value and flags.
  modport master (
    output d_in, wr, rd, inc, dec, push, pop,
    input  d_out, q, carry, zero, stk_full, stk_empty, stk_err
  );

  // The register itself.
  modport slave (
    input  d_in, wr, rd, inc, dec, push, pop,
    output d_out, q, carry, zero, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/counter_reg_3state.sv
// Loadable up/down register with a tri-state bus driver and a small LIFO
// save stack. Used as a program counter or stack pointer on the shared
// data bus: push+wr performs a CALL (save return value, load target) and
// pop performs a RET in a single cycle each.
module counter_reg_3state #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  counter_reg_3state_if.slave    bus
);

  // Address width of the stack memory; the pointer needs one extra bit
  // because it ranges over 0..DEPTH inclusive.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  logic [WIDTH-1:0] q_r,     q_nxt;
  logic             carry_r, carry_nxt;
  logic [PW-1:0]    ptr_r,   ptr_nxt;
  logic             err_r,   err_nxt;
  logic             push_we;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic             stk_full_w;
  logic             stk_empty_w;
  logic [PW-1:0]    ptr_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  assign stk_full_w  = (ptr_r == PTR_FULL);
  assign stk_empty_w = (ptr_r == '0);
  assign ptr_m1      = ptr_r - 1'b1;
  assign top_idx     = ptr_m1[AW-1:0];
  assign wr_idx      = ptr_r[AW-1:0];

  // Next-state: pop dominates everything; otherwise the value update and
  // the push run side by side, with push saving the pre-update value.
  always_comb begin
    q_nxt     = q_r;
    carry_nxt = carry_r;
    ptr_nxt   = ptr_r;
    err_nxt   = err_r;
    push_we   = 1'b0;
    if (bus.pop) begin
      if (!stk_empty_w) begin
        q_nxt     = stack_mem[top_idx];
        ptr_nxt   = ptr_m1;
        carry_nxt = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      if (bus.wr) begin
        q_nxt     = bus.d_in;
        carry_nxt = 1'b0;
      end else if (bus.inc && !bus.dec) begin
        q_nxt     = q_r + 1'b1;
        carry_nxt = (q_r == '1);
      end else if (bus.dec && !bus.inc) begin
        q_nxt     = q_r - 1'b1;
        carry_nxt = (q_r == '0);
      end
      if (bus.push) begin
        if (!stk_full_w) begin
          push_we = 1'b1;
          ptr_nxt = ptr_r + 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
    end
  end

  // Value, carry, pointer and sticky error; all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= RESET_VAL;
      carry_r <= 1'b0;
      ptr_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      q_r     <= q_nxt;
      carry_r <= carry_nxt;
      ptr_r   <= ptr_nxt;
      err_r   <= err_nxt;
    end
  end

  // Stack storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_we) begin
      stack_mem[wr_idx] <= q_r;
    end
  end

  // Outputs: value and flags straight from state, bus driven only on rd.
  assign bus.q         = q_r;
  assign bus.carry     = carry_r;
  assign bus.zero      = (q_r == '0);
  assign bus.stk_full  = stk_full_w;
  assign bus.stk_empty = stk_empty_w;
  assign bus.stk_err   = err_r;
  assign bus.d_out     = bus.rd ? q_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_counter_reg_3state.sv
// Directed test for counter_reg_3state (WIDTH=8, DEPTH=4, RESET_VAL=0).
module tb_counter_reg_3state;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Model of the save stack contents for the overflow sequence.
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  counter_reg_3state_if #(.WIDTH(8)) bus ();

  counter_reg_3state #(
    .WIDTH    (8),
    .DEPTH    (4),
    .RESET_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one command for one edge, then return to idle at edge+1.
  task automatic cmd(input logic w, input logic i, input logic d,
                     input logic pu, input logic po, input logic [7:0] din);
    bus.wr   = w;
    bus.inc  = i;
    bus.dec  = d;
    bus.push = pu;
    bus.pop  = po;
    bus.d_in = din;
    @(posedge clk);
    #1;
    bus.wr   = 1'b0;
    bus.inc  = 1'b0;
    bus.dec  = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.d_in = 8'h00;
    bus.wr   = 1'b0;
    bus.rd   = 1'b1;
    bus.inc  = 1'b0;
    bus.dec  = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;

    // Reset state
    #23;
    check("rst_q",     bus.q, 8'h00);
    check("rst_dout",  bus.d_out, 8'h00);
    check("rst_zero",  bus.zero, 1'b1);
    check("rst_empty", bus.stk_empty, 1'b1);
    check("rst_full",  bus.stk_full, 1'b0);
    check("rst_carry", bus.carry, 1'b0);
    check("rst_err",   bus.stk_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and increment through the wrap
    cmd(1, 0, 0, 0, 0, 8'hFE);
    check("ld_fe", bus.q, 8'hFE);
    cmd(0, 1, 0, 0, 0, 8'h00);
    check("inc1_q", bus.q, 8'hFF);
    check("inc1_c", bus.carry, 1'b0);
    cmd(0, 1, 0, 0, 0, 8'h00);
    check("inc2_q", bus.q, 8'h00);
    check("inc2_c", bus.carry, 1'b1);
    check("inc2_z", bus.zero, 1'b1);
    cmd(0, 1, 0, 0, 0, 8'h00);
    check("inc3_q", bus.q, 8'h01);
    check("inc3_c", bus.carry, 1'b0);
    check("inc3_z", bus.zero, 1'b0);

    // Decrement with borrow, then inc+dec together holds
    cmd(1, 0, 0, 0, 0, 8'h00);
    check("ld_00_c", bus.carry, 1'b0);
    cmd(0, 0, 1, 0, 0, 8'h00);
    check("dec_q", bus.q, 8'hFF);
    check("dec_c", bus.carry, 1'b1);
    cmd(0, 1, 1, 0, 0, 8'h00);
    check("incdec_q", bus.q, 8'hFF);
    check("incdec_c", bus.carry, 1'b1);

    // Bus driver follows rd combinationally
    bus.rd = 1'b0;
    #1;
    check("rd0_released", (bus.d_out !== bus.q), 1'b1);
    bus.rd = 1'b1;
    #1;
    check("rd1_dout", bus.d_out, 8'hFF);

    // CALL / RET
    cmd(1, 0, 0, 0, 0, 8'h10);
    cmd(1, 0, 0, 1, 0, 8'h80);
    check("call_q",     bus.q, 8'h80);
    check("call_empty", bus.stk_empty, 1'b0);
    cmd(0, 1, 0, 0, 0, 8'h00);
    cmd(0, 1, 0, 0, 0, 8'h00);
    check("call_inc_q", bus.q, 8'h82);
    cmd(0, 0, 0, 0, 1, 8'h00);
    check("ret_q",     bus.q, 8'h10);
    check("ret_empty", bus.stk_empty, 1'b1);
    check("ret_carry", bus.carry, 1'b0);

    // Overflow: push 01..04 while loading the next value, then a dropped fifth push
    cmd(1, 0, 0, 0, 0, 8'h01);
    for (int k = 2; k <= 5; k++) begin
      exp_q.push_back(bus.q);
      cmd(1, 0, 0, 1, 0, 8'(k));
    end
    check("ovf_full4", bus.stk_full, 1'b1);
    check("ovf_err4",  bus.stk_err, 1'b0);
    cmd(0, 0, 0, 1, 0, 8'h00);
    check("ovf_q5",    bus.q, 8'h05);
    check("ovf_full5", bus.stk_full, 1'b1);
    check("ovf_err5",  bus.stk_err, 1'b1);
    for (int k = 4; k >= 1; k--) begin
      cmd(0, 0, 0, 0, 1, 8'h00);
      exp_v = exp_q.pop_back();
      check("pop_q", bus.q, exp_v);
      check("pop_hand", bus.q, 8'(k));
    end
    check("pop_empty", bus.stk_empty, 1'b1);
    cmd(0, 0, 0, 0, 1, 8'h00);
    check("unf_q",   bus.q, 8'h01);
    check("unf_err", bus.stk_err, 1'b1);

    // Asynchronous reset mid-sequence (stk_err still set from above)
    cmd(1, 0, 0, 0, 0, 8'h33);
    cmd(1, 0, 0, 1, 0, 8'h44);
    cmd(1, 0, 0, 1, 0, 8'h55);
    check("pre_rst_q",     bus.q, 8'h55);
    check("pre_rst_empty", bus.stk_empty, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q",     bus.q, 8'h00);
    check("arst_empty", bus.stk_empty, 1'b1);
    check("arst_err",   bus.stk_err, 1'b0);
    check("arst_zero",  bus.zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset honours the command; push then pop round-trips
    cmd(1, 0, 0, 0, 0, 8'h5A);
    check("post_rst_q", bus.q, 8'h5A);
    cmd(1, 0, 0, 1, 0, 8'h11);
    check("b2b_push_q", bus.q, 8'h11);
    cmd(0, 0, 0, 0, 1, 8'h00);
    check("b2b_pop_q", bus.q, 8'h5A);
    check("b2b_empty", bus.stk_empty, 1'b1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
